// File: rtl/brick_field_ctrl.sv
// Brick wall owner: publishes brick geometry, scans the ball position for overlaps, clears
// struck bricks and keeps score. Optional multi-hit bricks: define BRICK_MULTI_HIT_EN.
module brick_field_ctrl #(
    parameter int unsigned BRICK_X0    = 140,
    parameter int unsigned BRICK_PITCH = 60,
    parameter int unsigned BRICK_Y     = 60,
    parameter int unsigned BRICK_W     = 57,
    parameter int unsigned BRICK_H     = 19,
    parameter int unsigned BALL_SZ     = 20,
    parameter int unsigned SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [8:0]         ball_x,
    input  logic [8:0]         ball_y,
    output logic [53:0]        brick_x_bus,
    output logic [53:0]        brick_y_bus,
    output logic [5:0]         bricks_exist,
    output logic               hit,
    output logic [2:0]         hit_idx,
    output logic [SCORE_W-1:0] score,
    output logic               level_clear
);

    typedef enum logic [1:0] {StIdle, StWait, StScan, StCleared} state_e;

    state_e             state_q, state_d;
    logic [5:0]         bricks_q, bricks_d;
    logic               hit_q, hit_d;
    logic [2:0]         hit_idx_q, hit_idx_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [8:0]         last_x_q, last_x_d;
    logic [8:0]         last_y_q, last_y_d;
    logic               block_valid_q, block_valid_d;
    logic [2:0]         block_idx_q, block_idx_d;
    logic [2:0]         idx_q, idx_d;
    logic               found_q, found_d;
`ifdef BRICK_MULTI_HIT_EN
    logic [5:0][1:0]    health_q, health_d;
`endif

    logic [9:0] bx, by, xi, yi;
    logic       overlap, eligible, load, kill;

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            brick_x_bus[9*i +: 9] = 9'(BRICK_X0 + 32'(i) * BRICK_PITCH);
            brick_y_bus[9*i +: 9] = 9'(BRICK_Y);
        end
    end

    // 10-bit sums so positions near 511 never wrap into a false overlap
    always_comb begin
        bx       = {1'b0, last_x_q};
        by       = {1'b0, last_y_q};
        xi       = 10'(BRICK_X0 + 32'(idx_q) * BRICK_PITCH);
        yi       = 10'(BRICK_Y);
        overlap  = (bx <= xi + 10'(BRICK_W)) && (bx + 10'(BALL_SZ) >= xi) &&
                   (by <= yi + 10'(BRICK_H)) && (by + 10'(BALL_SZ) >= yi);
        eligible = bricks_q[idx_q] && overlap && !(block_valid_q && block_idx_q == idx_q);
        load     = start && (state_q != StScan);
    end

    always_comb begin
        state_d       = state_q;
        bricks_d      = bricks_q;
        hit_d         = 1'b0;
        hit_idx_d     = hit_idx_q;
        score_d       = score_q;
        last_x_d      = last_x_q;
        last_y_d      = last_y_q;
        block_valid_d = block_valid_q;
        block_idx_d   = block_idx_q;
        idx_d         = idx_q;
        found_d       = found_q;
        kill          = 1'b0;
`ifdef BRICK_MULTI_HIT_EN
        health_d      = health_q;
`endif
        if (load) begin
            bricks_d      = 6'h3F;
            score_d       = '0;
            last_x_d      = ball_x;
            last_y_d      = ball_y;
            block_valid_d = 1'b0;
`ifdef BRICK_MULTI_HIT_EN
            for (int i = 0; i < 6; i++) health_d[i] = 2'd2;
`endif
            state_d       = StWait;
        end else begin
            case (state_q)
                StWait: begin
                    if ({ball_x, ball_y} != {last_x_q, last_y_q}) begin
                        last_x_d = ball_x;
                        last_y_d = ball_y;
                        idx_d    = 3'd0;
                        found_d  = 1'b0;
                        state_d  = StScan;
                    end
                end
                StScan: begin
                    // The block only lifts once the ball has left the brick it last hit
                    if (block_valid_q && block_idx_q == idx_q && !overlap) block_valid_d = 1'b0;
                    if (eligible && !found_q) begin
                        hit_d         = 1'b1;
                        hit_idx_d     = idx_q;
                        found_d       = 1'b1;
                        block_idx_d   = idx_q;
                        block_valid_d = 1'b1;
`ifdef BRICK_MULTI_HIT_EN
                        health_d[idx_q] = health_q[idx_q] - 2'd1;
                        kill            = (health_q[idx_q] == 2'd1);
`else
                        kill            = 1'b1;
`endif
                    end
                    if (kill) begin
                        bricks_d[idx_q] = 1'b0;
                        if (score_q != '1) score_d = score_q + 1'b1;
                    end
                    if (idx_q == 3'd5) begin
                        state_d = (bricks_d == 6'h00) ? StCleared : StWait;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            bricks_q      <= '0;
            hit_q         <= 1'b0;
            hit_idx_q     <= '0;
            score_q       <= '0;
            last_x_q      <= '0;
            last_y_q      <= '0;
            block_valid_q <= 1'b0;
            block_idx_q   <= '0;
            idx_q         <= '0;
            found_q       <= 1'b0;
`ifdef BRICK_MULTI_HIT_EN
            health_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            bricks_q      <= bricks_d;
            hit_q         <= hit_d;
            hit_idx_q     <= hit_idx_d;
            score_q       <= score_d;
            last_x_q      <= last_x_d;
            last_y_q      <= last_y_d;
            block_valid_q <= block_valid_d;
            block_idx_q   <= block_idx_d;
            idx_q         <= idx_d;
            found_q       <= found_d;
`ifdef BRICK_MULTI_HIT_EN
            health_q      <= health_d;
`endif
        end
    end

    assign bricks_exist = bricks_q;
    assign hit          = hit_q;
    assign hit_idx      = hit_idx_q;
    assign score        = score_q;
    assign level_clear  = (state_q == StCleared);

endmodule

// File: tb/tb_brick_field_ctrl.sv
// Bench for brick_field_ctrl: a per-scan reference model checked every cycle plus directed
// literal expectations for each scenario.
module tb_brick_field_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  ball_x = '0;
    logic [8:0]  ball_y = '0;
    logic [53:0] brick_x_bus, brick_y_bus;
    logic [5:0]  bricks_exist;
    logic        hit;
    logic [2:0]  hit_idx;
    logic [7:0]  score;
    logic        level_clear;

    int n_checks = 0;
    int n_pass   = 0;
    int hit_cnt  = 0;

`ifdef BRICK_MULTI_HIT_EN
    localparam int HITS = 2;
`else
    localparam int HITS = 1;
`endif

    brick_field_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .brick_x_bus  (brick_x_bus),
        .brick_y_bus  (brick_y_bus),
        .bricks_exist (bricks_exist),
        .hit          (hit),
        .hit_idx      (hit_idx),
        .score        (score),
        .level_clear  (level_clear)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: one decision per position update ----------------
    function automatic bit ovl(int bx, int by, int k);
        int xi = 140 + 60 * k;
        int yi = 60;
        return (bx <= xi + 57) && (bx + 20 >= xi) && (by <= yi + 19) && (by + 20 >= yi);
    endfunction

    function automatic int pick(int bx, int by, logic [5:0] alive, bit bv, int b);
        for (int k = 0; k < 6; k++)
            if (alive[k] && ovl(bx, by, k) && !(bv && b == k)) return k;
        return -1;
    endfunction

    int         m_state = 0;  // 0 idle, 1 waiting, 2 scanning, 3 cleared
    logic [5:0] m_bricks = '0;
    bit         m_hit = 0;
    int         m_hit_idx = 0;
    int         m_score = 0;
    logic [8:0] m_lx = '0, m_ly = '0;
    bit         m_bv = 0;
    int         m_b = 0;
    int         m_cnt = 0;
    int         m_tgt = -1;
    int         m_health [6] = '{default: 0};
    bit         m_kill;
    logic [5:0] m_final;

    always_comb begin
        m_kill = 1'b0;
        if (m_tgt >= 0 && m_tgt < 6) m_kill = (HITS == 1) || (m_health[m_tgt] == 1);
        m_final = m_bricks;
        if (m_state == 2 && m_cnt == m_tgt && m_kill) m_final = m_bricks & ~(6'b1 << m_tgt);
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state <= 0; m_bricks <= '0; m_hit <= 0; m_hit_idx <= 0; m_score <= 0;
            m_lx <= '0; m_ly <= '0; m_bv <= 0; m_b <= 0; m_cnt <= 0; m_tgt <= -1;
            for (int k = 0; k < 6; k++) m_health[k] <= 0;
        end else begin
            m_hit <= 0;
            if (m_state != 2 && start) begin
                m_bricks <= 6'h3F; m_score <= 0; m_lx <= ball_x; m_ly <= ball_y;
                m_bv <= 0; m_state <= 1;
                for (int k = 0; k < 6; k++) m_health[k] <= 2;
            end else if (m_state == 1 && (ball_x != m_lx || ball_y != m_ly)) begin
                m_lx  <= ball_x;
                m_ly  <= ball_y;
                m_tgt <= pick(int'(ball_x), int'(ball_y), m_bricks, m_bv, m_b);
                if (pick(int'(ball_x), int'(ball_y), m_bricks, m_bv, m_b) >= 0) begin
                    m_bv <= 1;
                    m_b  <= pick(int'(ball_x), int'(ball_y), m_bricks, m_bv, m_b);
                end else if (m_bv && !ovl(int'(ball_x), int'(ball_y), m_b)) begin
                    m_bv <= 0;
                end
                m_cnt   <= 0;
                m_state <= 2;
            end else if (m_state == 2) begin
                if (m_cnt == m_tgt) begin
                    m_hit     <= 1;
                    m_hit_idx <= m_tgt;
                    m_health[m_tgt] <= m_health[m_tgt] - 1;
                    m_bricks  <= m_final;
                    if (m_kill && m_score < 255) m_score <= m_score + 1;
                end
                if (m_cnt == 5) m_state <= (m_final == 6'h00) ? 3 : 1;
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    logic [53:0] exp_xb, exp_yb;
    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) begin
            exp_xb[9*i +: 9] = 9'(140 + 60 * i);
            exp_yb[9*i +: 9] = 9'd60;
        end
        n_checks++;
        if (bricks_exist === m_bricks && hit === m_hit && int'(hit_idx) == m_hit_idx &&
            int'(score) == m_score && level_clear === (m_state == 3) &&
            brick_x_bus === exp_xb && brick_y_bus === exp_yb) begin
            n_pass++;
        end else begin
            $display("FAIL cycle@%0t: exist=%h/%h hit=%b/%b idx=%0d/%0d score=%0d/%0d clr=%b/%b",
                     $time, bricks_exist, m_bricks, hit, m_hit, hit_idx, m_hit_idx, score,
                     m_score, level_clear, (m_state == 3));
        end
        if (hit === 1'b1) hit_cnt++;
    end

    // ---------------- directed literal checks ----------------
    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic move(int x, int y);
        ball_x = 9'(x);
        ball_y = 9'(y);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    int h0;

    initial begin
        cyc(3);
        rst = 1'b1;
        check("rst_exist", int'(bricks_exist), 0);
        check("rst_score", int'(score), 0);
        check("rst_clear", int'(level_clear), 0);
        check("rst_hit_idx", int'(hit_idx), 0);
        cyc(2);

        do_start();
        check("start_exist", int'(bricks_exist), 'h3F);
        check("start_score", int'(score), 0);
        check("x_bus_b2", int'(brick_x_bus[26:18]), 260);
        check("y_bus_b0", int'(brick_y_bus[8:0]), 60);

        // Single hit on brick 2: pulse at the third scan edge
        move(270, 70);
        cyc(3);
        check("hit_before", int'(hit), 0);
        cyc(1);
        check("hit_pulse", int'(hit), 1);
        check("hit_idx_2", int'(hit_idx), 2);
`ifndef BRICK_MULTI_HIT_EN
        check("exist_3b", int'(bricks_exist), 'h3B);
        check("score_1", int'(score), 1);
`endif
        cyc(1);
        check("hit_one_cycle", int'(hit), 0);
        h0 = hit_cnt;
        cyc(100);
        check("static_no_hit", hit_cnt, h0);

        // Two overlapped bricks: lowest wins, then the block steers to the next one
        do_start();
        move(250, 70);
        cyc(8);
        check("dual_idx_1", int'(hit_idx), 1);
        move(251, 70);
        cyc(8);
        check("block_idx_2", int'(hit_idx), 2);
`ifndef BRICK_MULTI_HIT_EN
        check("block_exist_39", int'(bricks_exist), 'h39);
        check("block_score_2", int'(score), 2);
`endif

        // Clear the wall
        do_start();
        h0 = hit_cnt;
        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < HITS; r++) begin
                move(150 + 60 * k, 70);
                cyc(8);
                move(0, 0);
                cyc(8);
            end
        end
        check("wall_hits", hit_cnt - h0, 6 * HITS);
        check("wall_score", int'(score), 6);
        check("wall_clear", int'(level_clear), 1);
        check("wall_exist", int'(bricks_exist), 0);
        h0 = hit_cnt;
        move(150, 70);
        cyc(8);
        check("cleared_no_hit", hit_cnt, h0);
        do_start();
        check("restart_exist", int'(bricks_exist), 'h3F);
        check("restart_clear", int'(level_clear), 0);

        // Reset in the middle of a scan, before brick 1 would be struck
        move(210, 70);
        cyc(2);
        h0 = hit_cnt;
        #1 rst = 1'b0;
        #1;
        check("midrst_exist", int'(bricks_exist), 0);
        check("midrst_hit", int'(hit), 0);
        check("midrst_score", int'(score), 0);
        check("midrst_idx", int'(hit_idx), 0);
        cyc(3);
        check("midrst_no_pulse", hit_cnt, h0);
        rst = 1'b1;
        cyc(2);

`ifdef BRICK_MULTI_HIT_EN
        do_start();
        move(150, 70);
        cyc(8);
        check("mh_first_exist", int'(bricks_exist), 'h3F);
        check("mh_first_idx", int'(hit_idx), 0);
        check("mh_first_score", int'(score), 0);
        move(0, 0);
        cyc(8);
        move(150, 70);
        cyc(2);
        check("mh_second_hit", int'(hit), 1);
        check("mh_second_exist", int'(bricks_exist), 'h3E);
        check("mh_second_score", int'(score), 1);
        cyc(6);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
